wave_capture_buffer: RTL and testbench
======================================

Name: wave_capture_buffer

Overview:
- Upstream stage of the scope's grid/wave pixel renderer; one instance per channel.
- Decimates the ADC sample stream and detects a level trigger, then captures one screen-width of samples into a ping-pong RAM.
- During display, the renderer's pixel-column counter sX indexes the display bank. The block returns the screen-row value compared against y (waveSigIn).
- The bank swap occurs only at frame start, so a frame never tears.

Parameters:
- DEPTH, 800, samples per capture (visible pixel columns).
- SAMPLE_W, 12, ADC sample width.
- AUTO_TIMEOUT, 65535, decimated samples in ARMED before a forced trigger.

Ports:
- clk  in  1  50MHz system clock (same clock as renderer).
- rst_n  in  1  synchronous active-low reset.
- sample_in  in  SAMPLE_W  ADC sample, unsigned.
- sample_valid  in  1  sample_in valid this cycle.
- run  in  1  1 = keep re-arming; 0 = stop after current capture.
- auto_en  in  1  enable forced trigger on timeout.
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- trig_level  in  SAMPLE_W  trigger threshold.
- decim  in  8  keep 1 of every (decim+1) valid samples.
- vsync  in  1  active-low vertical sync from the vsync generator.
- sX  in  11  renderer pixel-column counter.
- wave_out  out  14  screen row for column sX; 14'h3FFF means no trace.
- capture_done  out  1  one-cycle pulse when a bank swap occurs.
- armed  out  1  high in ARMED state.

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - state=IDLE, decimation counter=0, write address=0, timeout counter=0.
  - display bank=0, disp_valid=0, prev-sample reg=0.
  - wave_out=14'h3FFF, capture_done=0, armed=0.
- Reset mid-capture abandons the capture. RAM contents are not cleared; disp_valid=0 hides them.
- Decimation:
  - Counter counts valid samples 0..decim.
  - A sample is "kept" when counter==decim, then the counter returns to 0.
  - decim=0 keeps every valid sample.
  - decim changes take effect at the next counter wrap.
- Trigger, evaluated only on kept samples, comparing against the previous kept sample (prev):
  - Rising: prev < trig_level and cur >= trig_level.
  - Falling: prev > trig_level and cur <= trig_level.
  - prev updates on every kept sample in every state.
- States:
  - IDLE: if run, go to ARMED next cycle.
  - ARMED:
    - On trigger, write cur to address 0, set addr=1, go to CAPTURE.
    - Otherwise, if auto_en and timeout counter reaches AUTO_TIMEOUT, force a trigger in the same way.
    - The timeout counter increments per kept sample in ARMED and clears on leaving ARMED.
  - CAPTURE:
    - Each kept sample is written to the capture bank at addr, then addr increments.
    - When addr reaches DEPTH after a write, go to DONE.
  - DONE:
    - On vsync falling edge (registered vsync=1, current vsync=0): toggle display bank, set disp_valid=1, pulse capture_done, go to ARMED if run else IDLE.
    - Kept samples are ignored in DONE.
- run=0 during ARMED returns to IDLE next cycle. run=0 during CAPTURE finishes the capture normally.
- The capture bank is always the non-display bank; the display bank is never written.
- Readout:
  - wave_out is registered with 1-cycle latency from sX.
  - wave_out = {5'b0, ~mem[sX][SAMPLE_W-1 -: 9]}, i.e. 511 - (sample>>3), rows 0..511. Higher voltage maps to a lower row.
  - sX >= DEPTH or disp_valid=0 gives 14'h3FFF.
- Simultaneous events:
  - A kept sample in the same cycle as the vsync edge in DONE is dropped.
  - A trigger and timeout together count as one trigger.
  - sample_valid and reads coexist; the two RAM ports are independent.
- armed = (state==ARMED), registered.

Decomposition:
- Package scope_pkg:
  - state enum {IDLE, ARMED, CAPTURE, DONE}.
  - WAVE_NONE = 14'h3FFF.
  - SCREEN_W = 800.
  - Row-scaling shift = 3.
- Sub-module wave_bank_ram: 2*DEPTH x SAMPLE_W simple dual-port RAM.
  - One write port: {bank, addr}.
  - One registered read port.
  - Infers block RAM.

Test Plan:
- Reset: hold rst_n=0 for 3 clks with sX=10 -> wave_out=14'h3FFF, capture_done=0, armed=0; run=1 after release -> armed=1 within 2 clks.
- Rising trigger: trig_level=2048, decim=0, ramp samples 0,16,32,… -> capture starts at first sample >=2048. After a vsync falling edge: capture_done pulses once, and sX=0 gives wave_out=511-(2048>>3)=255 one clk later.
- Falling trigger and decimation: trig_falling=1, decim=3, descending ramp -> only every 4th valid sample is stored. Readout shows one row step per 4 input samples. No trigger fires on a rising crossing.
- Auto trigger: flat input 1000, trig_level=3000, auto_en=1, AUTO_TIMEOUT=16 -> capture starts after the 16th kept sample in ARMED. With auto_en=0 the block stays armed indefinitely.
- Frame integrity: complete a capture mid-frame -> wave_out for sX=0..799 is unchanged until the vsync falling edge, then switches in the same frame. sX=800 gives 14'h3FFF.
- Stop/reset mid-capture: drop run during CAPTURE -> capture completes, then IDLE after the swap. Assert rst_n=0 mid-capture -> wave_out=14'h3FFF until the next full capture and swap.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and constants for the per-channel wave capture path.
package scope_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [13:0] WAVE_NONE = 14'h3FFF;
    localparam int unsigned SCREEN_W  = 800;
    localparam int unsigned ROW_SHIFT = 3;
    localparam int unsigned ROW_BITS  = 9;
endpackage

// File: rtl/wave_capture_buffer_if.sv
// Sample/trigger controls in, renderer readout out; master = driver, slave = buffer.
interface wave_capture_buffer_if #(
    parameter int unsigned SAMPLE_W = 12
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                run;
    logic                auto_en;
    logic                trig_falling;
    logic [SAMPLE_W-1:0] trig_level;
    logic [7:0]          decim;
    logic                vsync;
    logic [10:0]         sX;
    logic [13:0]         wave_out;
    logic                capture_done;
    logic                armed;

    modport master (
        output sample_in, sample_valid, run, auto_en, trig_falling,
               trig_level, decim, vsync, sX,
        input  wave_out, capture_done, armed
    );

    modport slave (
        input  sample_in, sample_valid, run, auto_en, trig_falling,
               trig_level, decim, vsync, sX,
        output wave_out, capture_done, armed
    );
endinterface

// File: rtl/wave_capture_buffer_ram.sv
// Ping-pong sample store: two DEPTH-entry banks, one write port, one registered read port.
module wave_bank_ram #(
    parameter int unsigned DEPTH    = 800,
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic                i_wr_bank,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [SAMPLE_W-1:0] i_wr_data,
    input  logic                i_rd_bank,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [SAMPLE_W-1:0] o_rd_data
);
    localparam int unsigned IDX_W = $clog2(2 * DEPTH);

    logic [SAMPLE_W-1:0] r_mem [0:2*DEPTH-1];
    logic [SAMPLE_W-1:0] r_rd_data;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [IDX_W-1:0]    w_rd_idx;

    // Banks are packed back to back so 2*DEPTH entries suffice for non-power-of-two DEPTH.
    function automatic logic [IDX_W-1:0] lin_idx(input logic bank, input logic [ADDR_W-1:0] a);
        return bank ? (IDX_W'(DEPTH) + IDX_W'(a)) : IDX_W'(a);
    endfunction

    assign w_wr_idx  = lin_idx(i_wr_bank, i_wr_addr);
    assign w_rd_idx  = lin_idx(i_rd_bank, i_rd_addr);
    assign o_rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[w_wr_idx] <= i_wr_data;
        r_rd_data <= r_mem[w_rd_idx];
    end
endmodule

// File: rtl/wave_capture_buffer.sv
// Decimate, level-trigger and capture one screen of samples; serve the stable bank to the renderer.
module wave_capture_buffer
    import scope_pkg::*;
#(
    parameter int unsigned DEPTH        = SCREEN_W,
    parameter int unsigned SAMPLE_W     = 12,
    parameter int unsigned AUTO_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wave_capture_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(AUTO_TIMEOUT - 1);
    localparam logic [10:0]   SX_LIM    = 11'(DEPTH);

    state_t              r_state, w_state_nx;
    logic [7:0]          r_dec_cnt, r_dec_lim;
    logic [7:0]          w_dec_lim;
    logic                w_kept;
    logic [SAMPLE_W-1:0] r_prev;
    logic [TW-1:0]       r_tmo;
    logic [AW-1:0]       r_addr;
    logic                r_disp_bank, r_disp_valid;
    logic                r_vsync_d;
    logic                r_cap_done, r_armed, r_rd_hit;
    logic                w_trig, w_tmo_hit, w_vs_fall;
    logic                w_wr_en, w_swap;
    logic [AW-1:0]       w_wr_addr, w_rd_addr;
    logic [SAMPLE_W-1:0] w_rd_data;
    logic [ROW_BITS-1:0] w_row;

    // The keep limit is sampled at the start of each decimation period, so decim edits land on a wrap.
    assign w_dec_lim = (r_dec_cnt == '0) ? bus.decim : r_dec_lim;
    assign w_kept    = bus.sample_valid && (r_dec_cnt == w_dec_lim);

    assign w_trig = bus.trig_falling
                  ? ((r_prev > bus.trig_level) && (bus.sample_in <= bus.trig_level))
                  : ((r_prev < bus.trig_level) && (bus.sample_in >= bus.trig_level));
    assign w_tmo_hit = bus.auto_en && (r_tmo >= TMO_MAX);
    assign w_vs_fall = r_vsync_d && !bus.vsync;

    always_comb begin
        w_state_nx = r_state;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_addr;
        w_swap     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.run)
                    w_state_nx = ARMED;
            end
            ARMED: begin
                if (!bus.run) begin
                    w_state_nx = IDLE;
                end else if (w_kept && (w_trig || w_tmo_hit)) begin
                    w_wr_en    = 1'b1;
                    w_wr_addr  = '0;
                    w_state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_kept) begin
                    w_wr_en = 1'b1;
                    if (r_addr == ADDR_LAST)
                        w_state_nx = DONE;
                end
            end
            DONE: begin
                if (w_vs_fall) begin
                    w_swap     = 1'b1;
                    w_state_nx = bus.run ? ARMED : IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dec_cnt    <= '0;
            r_dec_lim    <= '0;
            r_prev       <= '0;
            r_tmo        <= '0;
            r_addr       <= '0;
            r_disp_bank  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_vsync_d    <= 1'b0;
            r_cap_done   <= 1'b0;
            r_armed      <= 1'b0;
            r_rd_hit     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_vsync_d  <= bus.vsync;
            r_cap_done <= w_swap;
            r_armed    <= (w_state_nx == ARMED);
            r_rd_hit   <= r_disp_valid && (bus.sX < SX_LIM);

            if (bus.sample_valid) begin
                if (r_dec_cnt == '0)
                    r_dec_lim <= bus.decim;
                r_dec_cnt <= w_kept ? '0 : r_dec_cnt + 8'd1;
            end
            if (w_kept)
                r_prev <= bus.sample_in;

            if (r_state != ARMED)
                r_tmo <= '0;
            else if (w_kept && (r_tmo != TMO_MAX))
                r_tmo <= r_tmo + 1'b1;

            if (w_wr_en)
                r_addr <= w_wr_addr + 1'b1;

            if (w_swap) begin
                r_disp_bank  <= ~r_disp_bank;
                r_disp_valid <= 1'b1;
            end
        end
    end

    assign w_rd_addr = (bus.sX < SX_LIM) ? bus.sX[AW-1:0] : '0;

    wave_bank_ram #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (~r_disp_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (bus.sample_in),
        .i_rd_bank (r_disp_bank),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Inverting before the shift maps high voltage to a low row: 511 - (sample >> 3).
    assign w_row = ROW_BITS'((~w_rd_data) >> ROW_SHIFT);

    assign bus.wave_out     = r_rd_hit ? 14'(w_row) : WAVE_NONE;
    assign bus.capture_done = r_cap_done;
    assign bus.armed        = r_armed;
endmodule

// File: tb/tb_wave_capture_buffer.sv
// Self-checking bench for wave_capture_buffer: directed tables, corner sequences, random traffic vs model.
module tb_wave_capture_buffer;
    localparam int DEPTH = 800;
    localparam int SW    = 12;
    localparam int TMO   = 16;
    localparam int NONE  = 'h3FFF;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_CAP   = 2;
    localparam int P_FULL  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    wave_capture_buffer_if #(.SAMPLE_W(SW)) bus ();

    wave_capture_buffer #(
        .DEPTH        (DEPTH),
        .SAMPLE_W     (SW),
        .AUTO_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_count = 0;

    // Reference model: phase, decimation, captured list and displayed screen.
    int m_phase = P_IDLE;
    int m_cnt = 0;
    int m_lim = 0;
    int m_prev = 0;
    int m_tmo = 0;
    int m_cap[$];
    int m_disp[DEPTH];
    bit m_disp_valid = 0;
    bit m_vs_prev = 0;

    typedef struct {
        bit falling;
        int lvl;
        int a;
        int b;
        bit exp_armed;
    } trig_vec_t;
    trig_vec_t tv[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int row_of(input int s);
        return 511 - (s >> 3);
    endfunction

    task automatic tick();
        int s, lvl, sx, nxt_wave;
        bit kept, trig, nxt_done;
        @(posedge clk);
        s   = int'(bus.sample_in);
        lvl = int'(bus.trig_level);
        sx  = int'(bus.sX);
        nxt_done = 0;
        nxt_wave = (m_disp_valid && sx < DEPTH) ? row_of(m_disp[sx]) : NONE;
        if (!rst_n) begin
            nxt_wave = NONE;
            m_phase = P_IDLE;
            m_cnt = 0;
            m_tmo = 0;
            m_prev = 0;
            m_disp_valid = 0;
            m_cap.delete();
        end else begin
            kept = 0;
            if (bus.sample_valid) begin
                if (m_cnt == 0) m_lim = int'(bus.decim);
                if (m_cnt == m_lim) begin
                    kept = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            trig = bus.trig_falling ? (m_prev > lvl && s <= lvl) : (m_prev < lvl && s >= lvl);
            case (m_phase)
                P_IDLE: if (bus.run) m_phase = P_ARMED;
                P_ARMED: begin
                    if (!bus.run) m_phase = P_IDLE;
                    else if (kept) begin
                        if (trig || (bus.auto_en && m_tmo + 1 >= TMO)) begin
                            m_cap.delete();
                            m_cap.push_back(s);
                            m_phase = P_CAP;
                        end else begin
                            m_tmo++;
                        end
                    end
                end
                P_CAP: if (kept) begin
                    m_cap.push_back(s);
                    if (m_cap.size() == DEPTH) m_phase = P_FULL;
                end
                default: if (m_vs_prev && !bus.vsync) begin
                    for (int i = 0; i < DEPTH; i++) m_disp[i] = m_cap[i];
                    m_disp_valid = 1;
                    nxt_done = 1;
                    m_phase = bus.run ? P_ARMED : P_IDLE;
                end
            endcase
            if (m_phase != P_ARMED) m_tmo = 0;
            if (kept) m_prev = s;
        end
        m_vs_prev = bus.vsync;
        #1;
        check("armed", int'(bus.armed), int'(m_phase == P_ARMED));
        check("capture_done", int'(bus.capture_done), int'(nxt_done));
        check("wave_out", int'(bus.wave_out), nxt_wave);
        if (bus.capture_done) done_count++;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic vsync_pulse();
        bus.vsync = 1'b0;
        tick();
        tick();
        bus.vsync = 1'b1;
        tick();
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int x = lo; x <= hi; x++) begin
            bus.sX = 11'(x);
            tick();
        end
    endtask

    // Arms, then feeds a 16-step ramp until one screen is captured.
    task automatic run_ramp_capture();
        int i;
        bus.trig_falling = 1'b0;
        bus.trig_level = 12'd2048;
        bus.decim = 8'd0;
        bus.auto_en = 1'b0;
        bus.run = 1'b1;
        bus.sample_valid = 1'b0;
        tick();
        tick();
        i = 0;
        while (m_phase != P_FULL && i < 5000) begin
            bus.sample_in = 12'((i * 16) & 'hFFF);
            bus.sample_valid = 1'b1;
            tick();
            i++;
        end
        bus.sample_valid = 1'b0;
        check("ramp_capture_bound", int'(m_phase == P_FULL), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, r0, r1, i;
        tv[0] = '{0, 100, 50, 100, 0};
        tv[1] = '{0, 100, 50, 99, 1};
        tv[2] = '{1, 100, 200, 100, 0};
        tv[3] = '{1, 100, 200, 101, 1};
        tv[4] = '{1, 100, 50, 150, 1};
        tv[5] = '{0, 0, 0, 4095, 1};
        tv[6] = '{1, 4095, 4095, 0, 1};
        tv[7] = '{0, 4095, 100, 4095, 0};

        bus.sample_in = '0;
        bus.sample_valid = 1'b0;
        bus.run = 1'b0;
        bus.auto_en = 1'b0;
        bus.trig_falling = 1'b0;
        bus.trig_level = 12'd2048;
        bus.decim = 8'd0;
        bus.vsync = 1'b1;
        bus.sX = 11'd10;

        // Reset state
        do_reset(3);
        check("reset_wave", int'(bus.wave_out), NONE);
        check("reset_done", int'(bus.capture_done), 0);
        check("reset_armed", int'(bus.armed), 0);
        bus.run = 1'b1;
        tick();
        tick();
        check("reset_arm_2clk", int'(bus.armed), 1);

        // Trigger edge table
        for (int k = 0; k < 8; k++) begin
            bus.run = 1'b0;
            do_reset(2);
            bus.decim = 8'd0;
            bus.auto_en = 1'b0;
            bus.trig_falling = tv[k].falling;
            bus.trig_level = 12'(tv[k].lvl);
            bus.run = 1'b1;
            tick();
            tick();
            bus.sample_in = 12'(tv[k].a);
            bus.sample_valid = 1'b1;
            tick();
            bus.sample_in = 12'(tv[k].b);
            tick();
            bus.sample_valid = 1'b0;
            check($sformatf("trig_row%0d", k), int'(bus.armed), int'(tv[k].exp_armed));
        end

        // Rising ramp capture and swap
        bus.run = 1'b0;
        do_reset(2);
        bus.sX = 11'd0;
        run_ramp_capture();
        c0 = done_count;
        vsync_pulse();
        check("ramp_done_once", done_count - c0, 1);
        bus.sX = 11'd0;
        tick();
        check("ramp_row0", int'(bus.wave_out), 255);
        sweep(0, DEPTH + 2);

        // Falling trigger with decimation and random valid gaps
        bus.run = 1'b0;
        do_reset(2);
        bus.trig_falling = 1'b1;
        bus.trig_level = 12'd3000;
        bus.decim = 8'd3;
        bus.run = 1'b1;
        tick();
        n = 0;
        i = 0;
        while (m_phase != P_FULL && i < 8000) begin
            bus.sample_valid = ($urandom_range(9) < 7);
            bus.sample_in = 12'((4095 - 2 * n) & 'hFFF);
            tick();
            if (bus.sample_valid) n++;
            i++;
        end
        bus.sample_valid = 1'b0;
        check("decim_capture_bound", int'(m_phase == P_FULL), 1);
        vsync_pulse();
        bus.sX = 11'd0;
        tick();
        r0 = int'(bus.wave_out);
        bus.sX = 11'd1;
        tick();
        r1 = int'(bus.wave_out);
        check("decim_row_step", r1 - r0, 1);
        sweep(0, DEPTH + 1);

        // Auto trigger after TMO kept samples
        bus.run = 1'b0;
        do_reset(2);
        bus.trig_falling = 1'b0;
        bus.trig_level = 12'd3000;
        bus.decim = 8'd0;
        bus.auto_en = 1'b1;
        bus.run = 1'b1;
        tick();
        tick();
        n = 0;
        while (bus.armed && n < 40) begin
            bus.sample_in = 12'd1000;
            bus.sample_valid = 1'b1;
            tick();
            n++;
        end
        bus.sample_valid = 1'b0;
        check("auto_kept_count", n, TMO);

        bus.run = 1'b0;
        do_reset(2);
        bus.auto_en = 1'b0;
        bus.run = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 100; k++) begin
            bus.sample_in = 12'd1000;
            bus.sample_valid = 1'b1;
            tick();
        end
        bus.sample_valid = 1'b0;
        check("auto_off_armed", int'(bus.armed), 1);

        // Frame integrity: old screen persists until the vsync edge
        bus.run = 1'b0;
        do_reset(2);
        run_ramp_capture();
        vsync_pulse();
        bus.run = 1'b1;
        bus.trig_level = 12'd1000;
        i = 0;
        while (m_phase != P_FULL && i < 5000) begin
            bus.sample_in = 12'($urandom_range(4095));
            bus.sample_valid = 1'b1;
            bus.sX = 11'(i % 900);
            tick();
            i++;
        end
        bus.sample_valid = 1'b0;
        sweep(0, DEPTH - 1);
        bus.vsync = 1'b0;
        sweep(0, 5);
        bus.vsync = 1'b1;
        sweep(0, DEPTH);
        check("frame_sx800", int'(bus.wave_out), NONE);

        // Stop during capture: finishes, swaps, then idles
        bus.run = 1'b0;
        do_reset(2);
        bus.trig_level = 12'd2048;
        bus.run = 1'b1;
        tick();
        tick();
        i = 0;
        while (m_cap.size() < 100 && i < 2000) begin
            bus.sample_in = 12'((i * 16) & 'hFFF);
            bus.sample_valid = 1'b1;
            tick();
            i++;
        end
        bus.run = 1'b0;
        while (m_phase != P_FULL && i < 4000) begin
            bus.sample_in = 12'((i * 16) & 'hFFF);
            tick();
            i++;
        end
        check("stop_capture_bound", int'(m_phase == P_FULL), 1);
        c0 = done_count;
        vsync_pulse();
        repeat (5) tick();
        bus.sample_valid = 1'b0;
        check("stop_done", done_count - c0, 1);
        check("stop_idle", int'(bus.armed), 0);

        // Reset mid-capture hides the screen until the next full capture
        bus.run = 1'b1;
        tick();
        tick();
        i = 0;
        while (m_cap.size() < 50 && i < 2000) begin
            bus.sample_in = 12'((i * 16) & 'hFFF);
            bus.sample_valid = 1'b1;
            tick();
            i++;
        end
        bus.sample_valid = 1'b0;
        bus.run = 1'b0;
        do_reset(2);
        sweep(0, 10);
        bus.sX = 11'd3;
        tick();
        check("rst_hidden", int'(bus.wave_out), NONE);
        run_ramp_capture();
        bus.sX = 11'd3;
        tick();
        check("rst_still_hidden", int'(bus.wave_out), NONE);
        vsync_pulse();
        bus.sX = 11'd0;
        tick();
        check("rst_recapture_row0", int'(bus.wave_out), 255);

        // Random traffic against the model
        bus.run = 1'b0;
        do_reset(2);
        bus.trig_level = 12'd2048;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (cyc % 5000 == 0) bus.trig_falling = 1'($urandom_range(1));
            if (cyc % 2500 == 0) bus.auto_en = 1'($urandom_range(1));
            if (cyc % 4000 == 0) bus.decim = 8'($urandom_range(2));
            bus.run = ((cyc / 3000) % 4) != 3;
            bus.sample_valid = ($urandom_range(3) != 0);
            bus.sample_in = 12'($urandom_range(4095));
            bus.vsync = (cyc % 1000) >= 3;
            bus.sX = 11'(cyc % 1056);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
